// File: rtl/fe_port_arbiter_if.sv
// Bus bundle for the #FE port arbiter: Z80 bus strobes, loader handshake and register outputs.
// Signal names follow the board schematic, hence the upper-case spelling.
interface fe_port_arbiter_if;
  logic [4:0] D;
  logic       WRn;
  logic       A0;
  logic       IORQn;
  logic       LD_REQ;
  logic [4:0] LD_D;
  logic       LD_ACK;
  logic       LD_OWN_TAPE;
  logic       K9;
  logic       K10;
  logic       K11;
  logic       TAPEOUT;
  logic       SOUND;
  logic [7:0] WR_CNT;

  modport master (
    output D, WRn, A0, IORQn, LD_REQ, LD_D, LD_OWN_TAPE,
    input  LD_ACK, K9, K10, K11, TAPEOUT, SOUND, WR_CNT
  );

  modport slave (
    input  D, WRn, A0, IORQn, LD_REQ, LD_D, LD_OWN_TAPE,
    output LD_ACK, K9, K10, K11, TAPEOUT, SOUND, WR_CNT
  );
endinterface

// File: rtl/fe_port_arbiter.sv
// Even-port (#FE) output register shared between synchronised Z80 I/O writes and a
// loader master; CPU writes win a same-cycle collision and the loader follows one cycle later.
module fe_port_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input logic             CLK,
  input logic             RESETn,
  fe_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, DONE} state_t;

  logic                          wr_raw;
  logic [SYNC_STAGES-1:0]        wr_pipe;
  logic [SYNC_STAGES-1:0][4:0]   d_pipe;
  logic                          wr_s;
  logic [4:0]                    d_s;
  state_t                        state, state_nxt;
  logic                          cpu_commit;
  logic                          ld_go;
  logic [4:0]                    fe_reg;
  logic                          ld_ack;
  logic [7:0]                    wr_cnt;

  assign wr_raw = ~bus.IORQn & ~bus.WRn & ~bus.A0;

  // D rides alongside the strobe so both leave the synchroniser together.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_pipe <= '0;
      d_pipe  <= '0;
    end else begin
      wr_pipe <= {wr_pipe[SYNC_STAGES-2:0], wr_raw};
      d_pipe  <= {d_pipe[SYNC_STAGES-2:0], bus.D};
    end
  end

  assign wr_s = wr_pipe[SYNC_STAGES-1];
  assign d_s  = d_pipe[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  // ARM needs a second high sample, so a single-cycle strobe is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_s)  state_nxt = ARM;
      ARM:     state_nxt = wr_s ? DONE : IDLE;
      DONE:    if (!wr_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_commit = 1'b0;
    if (state == ARM && wr_s) cpu_commit = 1'b1;
  end

  assign ld_go = bus.LD_REQ & ~cpu_commit;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fe_reg <= '0;
      ld_ack <= 1'b0;
      wr_cnt <= '0;
    end else begin
      ld_ack <= ld_go;
      if (cpu_commit)
        fe_reg <= {d_s[4], (bus.LD_OWN_TAPE ? fe_reg[3] : d_s[3]), d_s[2:0]};
      else if (bus.LD_REQ)
        fe_reg <= bus.LD_D;
      if (cpu_commit | ld_go)
        wr_cnt <= wr_cnt + 8'd1;
    end
  end

  assign bus.K9      = fe_reg[0];
  assign bus.K10     = fe_reg[1];
  assign bus.K11     = fe_reg[2];
  assign bus.TAPEOUT = fe_reg[3];
  assign bus.SOUND   = fe_reg[4];
  assign bus.LD_ACK  = ld_ack;
  assign bus.WR_CNT  = wr_cnt;
endmodule

// File: tb/tb_fe_port_arbiter.sv
// Directed bench for fe_port_arbiter: a sample-history model checked every cycle plus
// hand-computed expectations at the interesting points of each scenario.
module tb_fe_port_arbiter;
  localparam int SS = 2;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  fe_port_arbiter_if bus ();

  fe_port_arbiter #(.SYNC_STAGES(SS)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [4:0] out_reg();
    return {bus.SOUND, bus.TAPEOUT, bus.K11, bus.K10, bus.K9};
  endfunction

  // Model: a CPU write lands on the edge where the synchronised strobe shows its
  // second consecutive high sample; otherwise a pending loader request lands.
  logic       h_raw [0:SS+2];
  logic [4:0] h_d   [0:SS+2];
  logic [4:0] m_reg;
  logic       m_ack;
  logic [7:0] m_cnt;

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i <= SS + 2; i++) begin
        h_raw[i] = 1'b0;
        h_d[i]   = 5'd0;
      end
      m_reg = 5'd0;
      m_ack = 1'b0;
      m_cnt = 8'd0;
    end else begin
      logic cpu;
      for (int i = SS + 2; i > 0; i--) begin
        h_raw[i] = h_raw[i-1];
        h_d[i]   = h_d[i-1];
      end
      h_raw[0] = !bus.IORQn && !bus.WRn && !bus.A0;
      h_d[0]   = bus.D;
      cpu   = h_raw[SS] && h_raw[SS+1] && !h_raw[SS+2];
      m_ack = 1'b0;
      if (cpu) begin
        m_reg[2:0] = h_d[SS][2:0];
        m_reg[4]   = h_d[SS][4];
        if (!bus.LD_OWN_TAPE) m_reg[3] = h_d[SS][3];
      end else if (bus.LD_REQ) begin
        m_reg = bus.LD_D;
        m_ack = 1'b1;
      end
      if (cpu || m_ack) m_cnt = m_cnt + 8'd1;
    end
  end

  always @(negedge CLK) begin
    chk("cyc_reg", {27'd0, out_reg()}, {27'd0, m_reg});
    chk("cyc_ack", {31'd0, bus.LD_ACK}, {31'd0, m_ack});
    chk("cyc_cnt", {24'd0, bus.WR_CNT}, {24'd0, m_cnt});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic bus_wr(input logic [4:0] d);
    bus.D = d; bus.A0 = 1'b0; bus.IORQn = 1'b0; bus.WRn = 1'b0;
  endtask

  task automatic bus_idle();
    bus.WRn = 1'b1; bus.IORQn = 1'b1; bus.A0 = 1'b0;
  endtask

  initial begin
    bus.D = 5'd0; bus.LD_REQ = 1'b0; bus.LD_D = 5'd0; bus.LD_OWN_TAPE = 1'b0;
    bus_idle();
    cyc(3);
    RESETn = 1'b1;
    cyc(20);
    chk("idle_reg", {27'd0, out_reg()}, 32'h00);
    chk("idle_cnt", {24'd0, bus.WR_CNT}, 32'h0);
    chk("idle_ack", {31'd0, bus.LD_ACK}, 32'h0);

    // CPU write 10110: visible on the 4th edge, one commit despite a long strobe
    bus_wr(5'b10110);
    cyc(3);
    chk("cpu_lat3", {27'd0, out_reg()}, 32'h00);
    cyc(1);
    chk("cpu_lat4", {27'd0, out_reg()}, 32'b10110);
    chk("cpu_cnt1", {24'd0, bus.WR_CNT}, 32'd1);
    cyc(40);
    chk("cpu_hold", {24'd0, bus.WR_CNT}, 32'd1);
    bus_idle();
    cyc(6);

    // Non-matching decodes and a 1-cycle strobe leave the register alone
    bus_wr(5'b11111); bus.A0 = 1'b1;
    cyc(10);
    bus_idle();
    cyc(6);
    bus_wr(5'b11111); bus.IORQn = 1'b1;
    cyc(10);
    bus_idle();
    cyc(6);
    bus_wr(5'b11111);
    cyc(1);
    bus_idle();
    cyc(8);
    chk("rej_reg", {27'd0, out_reg()}, 32'b10110);
    chk("rej_cnt", {24'd0, bus.WR_CNT}, 32'd1);

    // Loader owns TAPEOUT
    bus.LD_OWN_TAPE = 1'b1;
    bus.LD_D = 5'b01000; bus.LD_REQ = 1'b1;
    cyc(1);
    chk("ld_ack", {31'd0, bus.LD_ACK}, 32'h1);
    chk("ld_reg", {27'd0, out_reg()}, 32'b01000);
    bus.LD_REQ = 1'b0;
    cyc(1);
    chk("ld_ack_drop", {31'd0, bus.LD_ACK}, 32'h0);
    bus_wr(5'b10001);
    cyc(4);
    chk("own_tape_reg", {27'd0, out_reg()}, 32'b11001);
    chk("own_tape_cnt", {24'd0, bus.WR_CNT}, 32'd3);
    bus_idle();
    cyc(6);

    // Collision: loader request sampled on the same edge as the CPU commit
    bus.LD_OWN_TAPE = 1'b0;
    bus_wr(5'b11000);
    cyc(3);
    bus.LD_D = 5'b00111; bus.LD_REQ = 1'b1;
    cyc(1);
    chk("col_cpu_reg", {27'd0, out_reg()}, 32'b11000);
    chk("col_no_ack", {31'd0, bus.LD_ACK}, 32'h0);
    cyc(1);
    chk("col_ld_ack", {31'd0, bus.LD_ACK}, 32'h1);
    chk("col_ld_reg", {27'd0, out_reg()}, 32'b00111);
    chk("col_cnt", {24'd0, bus.WR_CNT}, 32'd5);
    bus.LD_REQ = 1'b0;
    cyc(2);
    bus_idle();
    cyc(6);

    // Back-to-back loader writes from count 5: 250 more reach 255, one more wraps
    bus.LD_REQ = 1'b1;
    for (int i = 0; i < 250; i++) begin
      bus.LD_D = i[4:0];
      cyc(1);
    end
    chk("wrap_ff", {24'd0, bus.WR_CNT}, 32'hFF);
    bus.LD_D = 5'b11111;
    cyc(1);
    chk("wrap_00", {24'd0, bus.WR_CNT}, 32'h00);
    chk("wrap_reg", {27'd0, out_reg()}, 32'b11111);

    // Reset with the loader still requesting, then a bus write held across release
    bus.LD_D = 5'b01010;
    RESETn = 1'b0;
    cyc(2);
    chk("rst_ack", {31'd0, bus.LD_ACK}, 32'h0);
    chk("rst_reg", {27'd0, out_reg()}, 32'h00);
    chk("rst_cnt", {24'd0, bus.WR_CNT}, 32'h0);
    bus.LD_REQ = 1'b0;
    bus_wr(5'b00101);
    RESETn = 1'b1;
    cyc(3);
    chk("rst_wr_lat3", {27'd0, out_reg()}, 32'h00);
    cyc(1);
    chk("rst_wr_reg", {27'd0, out_reg()}, 32'b00101);
    chk("rst_wr_cnt", {24'd0, bus.WR_CNT}, 32'd1);
    bus_idle();
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fe_port_arbiter.md
Name: fe_port_arbiter

Overview:
- Synchronous owner of the even-port (#FE) output register: border bits K9/K10/K11, TAPEOUT and SOUND.
- Detects Z80 I/O writes (IORQn=0, WRn=0, A0=0) through a synchroniser and commits them in the system clock domain.
- Shares the same register with an internal loader/test master over a req/ack handshake.
- The loader can claim exclusive ownership of TAPEOUT for hardware tape-save.

Parameters:
- SYNC_STAGES, 2: flop stages on the bus strobe and D (allowed 2..4).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RESETn  input  1  asynchronous, active-low reset.
- D  input  5  Z80 data bus bits 4..0.
- WRn  input  1  Z80 write strobe, active low, asynchronous to CLK.
- A0  input  1  Z80 address bit 0.
- IORQn  input  1  Z80 I/O request, active low.
- LD_REQ  input  1  loader write request, level.
- LD_D  input  5  loader data, same bit map as D.
- LD_ACK  output  1  one-cycle pulse: the loader write was committed.
- LD_OWN_TAPE  input  1  1 = TAPEOUT is written only by the loader.
- K9, K10, K11  output  1 each  border colour (reg bits 0..2).
- TAPEOUT  output  1  reg bit 3.
- SOUND  output  1  reg bit 4.
- WR_CNT  output  8  count of committed writes from either source; wraps.

Behaviour:
- Reset (RESETn=0, async):
  - Output register = 5'b00000; LD_ACK=0; WR_CNT=0.
  - Synchroniser, commit flag and edge history cleared.
- Raw strobe: wr_raw = ~IORQn & ~WRn & ~A0. wr_raw and D pass through SYNC_STAGES flops, giving wr_s and d_s.
- CPU commit FSM, states IDLE, ARM, DONE:
  - IDLE: wr_s=1 -> ARM.
  - ARM: wr_s=1 -> cpu_commit this cycle using d_s, then -> DONE. wr_s=0 -> IDLE with no write (glitch reject).
  - DONE: stays until wr_s=0 -> IDLE. Exactly one commit per bus write however long WRn is held.
- CPU latency: the register updates on the (SYNC_STAGES+2)th rising CLK edge after wr_raw is first sampled high. WRn must stay low for at least SYNC_STAGES+2 CLK periods. Shorter strobes are either rejected entirely or committed once; never partially.
- CPU data merge:
  - reg[2:0] = d_s[2:0]; reg[4] = d_s[4].
  - reg[3] = d_s[3] if LD_OWN_TAPE=0, otherwise unchanged.
- Loader handshake:
  - LD_REQ is sampled every cycle. If LD_REQ=1 and no cpu_commit this cycle, then reg <= LD_D (all 5 bits, including bit 3 regardless of LD_OWN_TAPE) and LD_ACK=1 for that cycle.
  - LD_ACK is registered and high together with the register update edge.
  - The master must drop LD_REQ or present new LD_D in the cycle after LD_ACK. If LD_REQ is still high, a second write commits (back-to-back allowed, one per cycle).
  - LD_REQ dropped before ack: no write, no ack.
- Arbitration: a CPU commit has priority in the same cycle. The loader is deferred by exactly that one cycle (the CPU commits at most once per bus write), so the loader never starves.
- WR_CNT: +1 on every cycle with cpu_commit or LD_ACK. Both can never happen in one cycle. Wraps 8'hFF -> 8'h00.
- LD_OWN_TAPE changes take effect on the next commit only; no output change by themselves.
- Reset mid-operation: a pending loader request is dropped (no ack). A bus write still held after RESETn deasserts is seen as a new edge and committed once, after normal latency.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: all outputs 0, WR_CNT=0, LD_ACK=0 for 20 cycles.
- CPU write D=5'b10110 (A0=0, IORQn=0, WRn low for 8 CLK, SYNC_STAGES=2):
  - {SOUND,TAPEOUT,K11,K10,K9}=10110 on the 4th edge after the strobe.
  - WR_CNT=1; held 40 cycles -> still a single commit.
- A0=1 or IORQn=1 with WRn low, and a WRn low pulse of 1 CLK: register unchanged, WR_CNT unchanged.
- LD_OWN_TAPE=1:
  - Loader writes 01000 -> LD_ACK pulses, TAPEOUT=1.
  - CPU then writes 10001 -> K9=1, SOUND=1, TAPEOUT stays 1.
- Loader LD_REQ with LD_D=00111 held while the CPU commit of 11000 lands in the same cycle:
  - CPU result 11000 appears first, no ack that cycle.
  - Next cycle LD_ACK=1 and reg=00111; WR_CNT increments by 2 in total.
- Counter wrap: 256 loader writes -> WR_CNT returns to 0. RESETn pulsed low mid-request -> no LD_ACK, outputs 0.
